// File: rtl/stream_fork_dyn_pkg.sv
// Shared types and helpers for the dynamic-mask stream fork.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package stream_fork_dyn_pkg;

    localparam int N_OUP_DEFAULT      = 2;
    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int CNT_WIDTH_DEFAULT  = 16;

    // Occupancy of the optional input register stage.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } beat_state_e;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    // The caller truncates the result back to its own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val == max_val) ? val : (val + 64'd1);
    endfunction

endpackage

// File: rtl/stream_fork_dyn_core.sv
// Per-beat delivery tracker: drives per-output valids and decides when the beat is released.
// Latency: combinational from the current beat to valid_o/release_o; done_q updates on clk_i.
// Backpressure: release_o stays low until every selected output has handshaked.
// Ports: clk_i/rst_i, cur_v_i/cur_sel_i (current beat), ready_i (per output),
//        valid_o (per output), release_o (beat fully delivered this cycle).
module stream_fork_dyn_core
    import stream_fork_dyn_pkg::*;
#(
    parameter int N_OUP = N_OUP_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cur_v_i,
    input  logic [N_OUP-1:0] cur_sel_i,
    input  logic [N_OUP-1:0] ready_i,
    output logic [N_OUP-1:0] valid_o,
    output logic             release_o
);

    logic [N_OUP-1:0] done_q;
    logic [N_OUP-1:0] done_d;
    logic [N_OUP-1:0] hs;

    always_comb begin
        // Outputs that already took this beat are masked so nobody sees it twice.
        valid_o   = {N_OUP{cur_v_i}} & cur_sel_i & ~done_q;
        hs        = valid_o & ready_i;
        // Every output is either unselected, already served, or served now.
        // An all-zero mask therefore releases immediately (beat dropped).
        release_o = cur_v_i & (&(~cur_sel_i | done_q | hs));
        done_d    = release_o ? '0 : (done_q | hs);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/stream_fork_dyn.sv
// Ready-valid fork delivering each beat once to every output selected by sel_i.
// Latency: 0 cycles (REG_EN=0) or 1 cycle through a one-entry register (REG_EN=1).
// Backpressure: input is consumed only once all selected outputs have handshaked.
// Ports: clk_i, rst_i (async active-high), data_i/sel_i/valid_i/ready_o (input stream),
//        data_o/valid_o/ready_i (per-output streams), txn_cnt_o/stall_cnt_o (statistics).
// Build option: define STREAM_FORK_DYN_CNT_EN to build the saturating statistics counters;
//        otherwise both counter ports read zero and no counter flops exist.
module stream_fork_dyn
    import stream_fork_dyn_pkg::*;
#(
    parameter int N_OUP      = N_OUP_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int REG_EN     = 0,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [N_OUP-1:0]      sel_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [N_OUP-1:0]      valid_o,
    input  logic [N_OUP-1:0]      ready_i,
    output logic [CNT_WIDTH-1:0]  txn_cnt_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    logic                  cur_v;
    logic [N_OUP-1:0]      cur_sel;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  rel;
    logic                  ready_int;

    if (REG_EN == 0) begin : g_pass
        // Reset forces the beat invisible so nothing handshakes while rst_i is high.
        assign cur_v     = valid_i & ~rst_i;
        assign cur_sel   = sel_i;
        assign cur_data  = data_i;
        assign ready_int = rel;
    end else begin : g_reg
        beat_state_e           state_q, state_d;
        logic [N_OUP-1:0]      sel_q, sel_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  full_q;
        logic                  in_hs;

        assign full_q = (state_q == FULL);
        assign in_hs  = valid_i & ready_o;

        always_comb begin
            state_d = state_q;
            sel_d   = sel_q;
            data_d  = data_q;
            // A load wins over a release so release+load keeps one beat per cycle.
            if (in_hs) begin
                state_d = FULL;
                sel_d   = sel_i;
                data_d  = data_i;
            end else if (rel) begin
                state_d = EMPTY;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= EMPTY;
                sel_q   <= '0;
                data_q  <= '0;
            end else begin
                state_q <= state_d;
                sel_q   <= sel_d;
                data_q  <= data_d;
            end
        end

        assign cur_v     = full_q;
        assign cur_sel   = sel_q;
        assign cur_data  = data_q;
        // Only a full register couples ready_o to ready_i (through rel).
        assign ready_int = ~full_q | rel;
    end

    stream_fork_dyn_core #(
        .N_OUP (N_OUP)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cur_v_i   (cur_v),
        .cur_sel_i (cur_sel),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .release_o (rel)
    );

    assign data_o  = cur_data;
    assign ready_o = ready_int & ~rst_i;

`ifdef STREAM_FORK_DYN_CNT_EN
    logic [CNT_WIDTH-1:0] txn_cnt_q, txn_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        txn_cnt_d   = txn_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (valid_i & ready_o) begin
            txn_cnt_d = CNT_WIDTH'(sat_inc(64'(txn_cnt_q), CNT_WIDTH));
        end
        if (valid_i & ~ready_o) begin
            stall_cnt_d = CNT_WIDTH'(sat_inc(64'(stall_cnt_q), CNT_WIDTH));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txn_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            txn_cnt_q   <= txn_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign txn_cnt_o   = txn_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign txn_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    if (N_OUP < 1) begin : g_chk_n_oup
        $error("stream_fork_dyn: N_OUP must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_chk_data_width
        $error("stream_fork_dyn: DATA_WIDTH must be >= 1");
    end

    // A stalled beat must be held unchanged until it is accepted.
    property p_hold_under_backpressure;
        @(posedge clk_i) disable iff (rst_i)
            (valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(sel_i));
    endproperty
    a_hold_under_backpressure: assert property (p_hold_under_backpressure)
        else $error("stream_fork_dyn: input changed or dropped while stalled");
`endif

endmodule
